// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: hunts for COM byte alignment on an MSB-first bit
// stream, locks after a run of aligned COMs, then delivers non-COM data bytes.
module serial_parallel_rx #(
   parameter logic [7:0]  COM_BYTE   = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       Data_in,
   output logic [7:0] Data_out,
   output logic       valid_out,
   output logic       active
);

   // state  | meaning
   // SEARCH | sliding bit-by-bit hunt for COM_BYTE
   // ALIGN  | counting consecutive COMs on the candidate byte grid
   // LOCKED | aligned; deliver non-COM bytes at each byte boundary
   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

   state_t     state_q;
   logic [6:0] sr_q;
   logic [2:0] bit_cnt_q;
   logic [3:0] com_cnt_q;

   logic [7:0] word;
   logic       is_com;
   logic       boundary;

   assign word     = {sr_q, Data_in};
   assign is_com   = (word == COM_BYTE);
   assign boundary = (bit_cnt_q == 3'd7);

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q   <= SEARCH;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
         Data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         sr_q      <= word[6:0];
         bit_cnt_q <= bit_cnt_q + 3'd1;
         case (state_q)
            SEARCH: begin
               if (is_com) begin
                  // restart the byte grid so the next 8 edges form one byte
                  bit_cnt_q <= 3'd0;
                  com_cnt_q <= 4'd1;
                  if (LOCK_N == 4'd1) begin
                     state_q <= LOCKED;
                     active  <= 1'b1;
                  end else begin
                     state_q <= ALIGN;
                  end
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (is_com) begin
                     com_cnt_q <= com_cnt_q + 4'd1;
                     if (com_cnt_q + 4'd1 == LOCK_N) begin
                        state_q <= LOCKED;
                        active  <= 1'b1;
                     end
                  end else begin
                     state_q   <= SEARCH;
                     com_cnt_q <= 4'd0;
                  end
               end
            end
            LOCKED: begin
               // no realignment here: straddling COM patterns are plain data bits
               if (boundary) begin
                  if (is_com) begin
                     valid_out <= 1'b0;
                  end else begin
                     Data_out  <= word;
                     valid_out <= 1'b1;
                  end
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

endmodule

// File: doc/serial_parallel_rx.md
Name: serial_parallel_rx

Overview:
- Receive-side counterpart of the PHY-TX parallel-to-serial stage.
- Samples a 1-bit MSB-first serial stream at clk_32f and finds byte alignment by hunting for the COM idle byte (0xBC).
- Declares link active after a run of consecutive aligned COMs, then delivers 8-bit data bytes with a valid flag.
- Sits at the PHY-RX input, feeding the byte-level (clk_4f-rate) logic downstream.

Parameters:
- COM_BYTE, 8'hBC, idle/alignment symbol sent by the transmitter when it has no valid data.
- LOCK_COUNT, 4, consecutive aligned COM bytes required to enter LOCKED (legal range 1..15).

Ports:
- clk_32f  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Data_in  input  1  serial data, MSB of each byte first.
- Data_out  output  8  last received non-COM byte.
- valid_out  output  1  1 while Data_out holds a freshly received non-COM byte.
- active  output  1  1 once alignment is locked.

Behaviour:
- Reset (reset==0, asynchronous): shift register 0, bit counter 0, COM counter 0, state SEARCH, Data_out=8'h00, valid_out=0, active=0. All outputs are registered.
- Every posedge: sr <= {sr[6:0], Data_in}. Let word = {sr[6:0], Data_in}, the byte completed at this edge. All decisions below use word at the same edge.
- Bit counter (3-bit) increments each edge and wraps 7->0. A "boundary" is an edge where the counter equals 7, i.e. the 8th bit of a byte is being sampled.
- SEARCH:
  - Evaluate word on every edge, with no boundary restriction.
  - If word==COM_BYTE: force the bit counter to 0 so the next 8 edges form the next byte, and set COM count=1.
  - Then, if LOCK_COUNT==1, go to LOCKED and set active=1; otherwise go to ALIGN.
- ALIGN: evaluate only at boundaries.
  - word==COM_BYTE: COM count+1. If the count reaches LOCK_COUNT, go to LOCKED and set active=1 at that same edge.
  - word!=COM_BYTE: go to SEARCH and clear the COM count. Re-hunting starts with the following edge.
- LOCKED: evaluate only at boundaries.
  - word!=COM_BYTE: Data_out<=word, valid_out<=1.
  - word==COM_BYTE: valid_out<=0; Data_out holds its previous value.
  - Data_out and valid_out are therefore stable for 8 clocks, from one boundary to the next.
  - No realignment in LOCKED: COM patterns that straddle a boundary are ignored.
  - active is sticky until reset.
- Latency: a byte whose LSB is sampled at edge N appears on Data_out and valid_out right after edge N.
- Lock timing: if the first COM completes at edge K (in SEARCH), active rises at edge K+8*(LOCK_COUNT-1).
- Reset mid-operation: immediate return to the reset state. Re-lock needs a fresh LOCK_COUNT COM run.
- A data byte equal to COM_BYTE cannot be conveyed; the transmitter never sends it as data.

Test Plan:
- Reset: hold reset=0 for 5 clocks with random Data_in -> Data_out=8'h00, valid_out=0, active=0 throughout. Release -> outputs unchanged until lock.
- Lock with offset: 3 random bits, then continuous 0xBC MSB-first, first COM complete at edge K -> active=0 through K+23, active=1 after K+24, valid_out stays 0.
- Data after lock: after lock, send 0x5A, 0x3C, 0xBC -> Data_out=0x5A with valid_out=1 for 8 clocks, then 0x3C with valid_out=1 for 8 clocks, then valid_out=0 with Data_out=0x3C held.
- Broken alignment: send 0xBC, 0xBC, 0xBC, 0x00, then 4x 0xBC -> active stays 0 after the 0x00 (back to SEARCH); active=1 at the 4th COM of the second run.
- Straddled COM in LOCKED: after lock, send 0x0B, 0xC0 (bit stream contains 0xBC across the boundary) -> Data_out=0x0B then 0xC0, both with valid_out=1, no realignment.
- Async reset mid-LOCKED: drop reset between clock edges while valid_out=1 -> Data_out=0, valid_out=0, active=0 immediately. After release, 4x 0xBC re-lock.
